// File: rtl/alu_muldiv.sv
// ALU with an iterative multiply/divide unit and HI/LO registers.
// The MD unit runs one shift-add or restoring-divide step per cycle for WIDTH cycles.
module alu_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   Ainput,
  input  logic [WIDTH-1:0]   Binput,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [4:0]         Op,
  input  logic               Start,
  output logic [WIDTH-1:0]   ALU_Result,
  output logic               Zero,
  output logic               Busy,
  output logic               Done,
  output logic               Div_zero,
  output logic               Stall
);

  localparam logic [4:0] OpAnd  = 5'd0,  OpOr   = 5'd1,  OpAdd  = 5'd2,  OpSub  = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4,  OpNor  = 5'd5,  OpSlt  = 5'd6,  OpSltu = 5'd7;
  localparam logic [4:0] OpSll  = 5'd8,  OpSrl  = 5'd9,  OpSra  = 5'd10, OpSllv = 5'd11;
  localparam logic [4:0] OpSrlv = 5'd12, OpSrav = 5'd13, OpLui  = 5'd14, OpMfhi = 5'd15;
  localparam logic [4:0] OpMflo = 5'd16, OpMthi = 5'd17, OpMtlo = 5'd18, OpMult = 5'd19;
  localparam logic [4:0] OpMultu = 5'd20, OpDiv = 5'd21, OpDivu = 5'd22;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               r_state, w_state_next;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_hi, r_lo, r_a, r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_is_div, r_neg_q, r_neg_r, r_div0;

  logic                 w_is_md, w_start, w_accept, w_signed, w_op_div, w_last;
  logic                 w_a_neg, w_b_neg, w_ge;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_acc_hi, w_acc_lo, w_rem, w_quo, w_rem_f;
  logic [WIDTH-1:0]     w_alu, w_md_hi, w_md_lo;
  logic [SHAMT_W-1:0]   w_vsh;
  logic [WIDTH:0]       w_sum, w_shift;
  logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_next, w_prod;

  assign w_is_md  = (Op >= OpMult) && (Op <= OpDivu);
  assign w_start  = Start && w_is_md;
  assign w_signed = (Op == OpMult) || (Op == OpDiv);
  assign w_op_div = (Op == OpDiv) || (Op == OpDivu);
  assign w_a_neg  = w_signed && Ainput[WIDTH-1];
  assign w_b_neg  = w_signed && Binput[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -Ainput : Ainput;
  assign w_b_mag  = w_b_neg ? -Binput : Binput;

  assign Busy     = (r_state == StRun);
  assign Done     = (r_state == StDone);
  assign Div_zero = Done && r_div0;
  assign Stall    = Busy && (((Op >= OpMfhi) && (Op <= OpMtlo)) || w_start);
  assign w_accept = w_start && (r_state != StRun);
  assign w_last   = Busy && (r_cnt == SHAMT_W'(WIDTH - 1));

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_acc_hi   = r_acc[2*WIDTH-1:WIDTH];
  assign w_acc_lo   = r_acc[WIDTH-1:0];
  assign w_sum      = {1'b0, w_acc_hi} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_sum, w_acc_lo[WIDTH-1:1]}
                               : {1'b0, w_acc_hi, w_acc_lo[WIDTH-1:1]};
  assign w_shift    = {w_acc_hi, w_acc_lo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_rem      = w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
  assign w_div_next = {w_rem, w_acc_lo[WIDTH-2:0], w_ge};
  assign w_next     = r_is_div ? w_div_next : w_mul_next;

  // Sign fix-up applied to the final step so HI/LO are correct in the DONE cycle.
  assign w_prod  = r_neg_q ? -w_next : w_next;
  assign w_quo   = r_neg_q ? -w_next[WIDTH-1:0] : w_next[WIDTH-1:0];
  assign w_rem_f = r_neg_r ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];

  always_comb begin
    w_md_hi = w_prod[2*WIDTH-1:WIDTH];
    w_md_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_md_hi = r_div0 ? r_a : w_rem_f;
      w_md_lo = r_div0 ? '1  : w_quo;
    end
  end

  assign w_vsh = Ainput[SHAMT_W-1:0];

  always_comb begin
    w_alu = '0;
    case (Op)
      OpAnd:   w_alu = Ainput & Binput;
      OpOr:    w_alu = Ainput | Binput;
      OpAdd:   w_alu = Ainput + Binput;
      OpSub:   w_alu = Ainput - Binput;
      OpXor:   w_alu = Ainput ^ Binput;
      OpNor:   w_alu = ~(Ainput | Binput);
      OpSlt:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(Ainput) < $signed(Binput))};
      OpSltu:  w_alu = {{(WIDTH-1){1'b0}}, (Ainput < Binput)};
      OpSll:   w_alu = Binput << Shamt;
      OpSrl:   w_alu = Binput >> Shamt;
      OpSra:   w_alu = $signed(Binput) >>> Shamt;
      OpSllv:  w_alu = Binput << w_vsh;
      OpSrlv:  w_alu = Binput >> w_vsh;
      OpSrav:  w_alu = $signed(Binput) >>> w_vsh;
      OpLui:   w_alu = {Binput[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OpMfhi:  w_alu = r_hi;
      OpMflo:  w_alu = r_lo;
      OpMthi:  w_alu = Ainput;
      OpMtlo:  w_alu = Ainput;
      default: w_alu = '0;
    endcase
  end

  assign ALU_Result = w_alu;
  assign Zero       = (w_alu == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = w_start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
        r_a      <= Ainput;
        r_b      <= w_b_mag;
        r_is_div <= w_op_div;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_div0   <= w_op_div && (Binput == '0);
      end else if (Busy) begin
        r_acc <= w_next;
        r_cnt <= r_cnt + SHAMT_W'(1);
        if (w_last) begin
          r_hi <= w_md_hi;
          r_lo <= w_md_lo;
        end
      end
      // MT writes are blocked by Stall while running, so they never collide with the MD write.
      if (!Stall && (Op == OpMthi)) r_hi <= Ainput;
      if (!Stall && (Op == OpMtlo)) r_lo <= Ainput;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=16.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic [4:0]  sh32 = '0, op32 = 5'd2;
  logic        st32 = 1'b0, zero32, busy32, done32, dz32, stall32;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic [3:0]  sh16 = '0;
  logic [4:0]  op16 = 5'd2;
  logic        st16 = 1'b0, zero16, busy16, done16, dz16, stall16;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock(clk), .reset(rst), .Ainput(a32), .Binput(b32), .Shamt(sh32), .Op(op32),
    .Start(st32), .ALU_Result(res32), .Zero(zero32), .Busy(busy32), .Done(done32),
    .Div_zero(dz32), .Stall(stall32)
  );

  alu_muldiv #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clock(clk), .reset(rst), .Ainput(a16), .Binput(b16), .Shamt(sh16), .Op(op16),
    .Start(st16), .ALU_Result(res16), .Zero(zero16), .Busy(busy16), .Done(done16),
    .Div_zero(dz16), .Stall(stall16)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  task automatic launch32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op32 = op; a32 = a; b32 = b; st32 = 1'b1;
    @(posedge clk);
    #1 st32 = 1'b0;
  endtask

  // Returns busy-cycle count and the sample index (1 = first cycle after accept) of Done.
  task automatic wait32(output int nbusy, output int idx);
    nbusy = 0; idx = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk); #1;
      if (done32) begin idx = i; break; end
      if (busy32) nbusy++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    total++; if ({busy32, done32, dz32, stall32} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {busy32, done32, dz32, stall32});
    end
    op32 = 5'd15; #1;
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", res32); end
    op32 = 5'd16; #1;
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", res32); end
  endtask

  task automatic test_alu;
    vec_t vt [19];
    vt = '{
      '{5'd0,  32'hF0F000FF, 32'h0FF00F0F, 5'd0,  32'h00F0000F},
      '{5'd1,  32'hF0F000FF, 32'h0FF00F0F, 5'd0,  32'hFFF00FFF},
      '{5'd2,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000},
      '{5'd3,  32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE},
      '{5'd4,  32'hF0F000FF, 32'h0FF00F0F, 5'd0,  32'hFF000FF0},
      '{5'd5,  32'hF0F000FF, 32'h0FF00F0F, 5'd0,  32'h000FF000},
      '{5'd6,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001},
      '{5'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000},
      '{5'd7,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000001},
      '{5'd8,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000},
      '{5'd9,  32'h00000000, 32'h80000000, 5'd4,  32'h08000000},
      '{5'd10, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000},
      '{5'd11, 32'h00000024, 32'h00000003, 5'd1,  32'h00000030},
      '{5'd12, 32'h00000021, 32'h80000000, 5'd0,  32'h40000000},
      '{5'd13, 32'h0000003F, 32'h80000000, 5'd0,  32'hFFFFFFFF},
      '{5'd14, 32'h00000000, 32'h00001234, 5'd0,  32'h12340000},
      '{5'd14, 32'h00000000, 32'hABCD1234, 5'd0,  32'h12340000},
      '{5'd17, 32'h13579BDF, 32'h00000000, 5'd0,  32'h13579BDF},
      '{5'd26, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000}
    };
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      op32 = vt[i].op; a32 = vt[i].a; b32 = vt[i].b; sh32 = vt[i].sh;
      #1;
      total++; if (res32 !== vt[i].exp) begin
        bad++; $display("FAIL alu[%0d] op=%0d got=%h want=%h", i, vt[i].op, res32, vt[i].exp);
      end
      total++; if (zero32 !== (vt[i].exp == 32'h0)) begin
        bad++; $display("FAIL zero[%0d] got=%b want=%b", i, zero32, (vt[i].exp == 32'h0));
      end
    end
    sh32 = '0;
  endtask

  task automatic test_mt;
    @(negedge clk); op32 = 5'd17; a32 = 32'hDEADBEEF;
    @(negedge clk); op32 = 5'd18; a32 = 32'h0BADF00D;
    @(negedge clk); op32 = 5'd15; #1;
    total++; if (res32 !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi got=%h want=deadbeef", res32); end
    op32 = 5'd16; #1;
    total++; if (res32 !== 32'h0BADF00D) begin bad++; $display("FAIL mtlo got=%h want=0badf00d", res32); end
  endtask

  task automatic check_md(input string name, input int nbusy, input int idx,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    total++; if (nbusy != 32 || idx != 33) begin
      bad++; $display("FAIL %s_latency busy=%0d done_at=%0d want busy=32 done_at=33", name, nbusy, idx);
    end
    total++; if (dz32 !== dz) begin bad++; $display("FAIL %s_divzero got=%b want=%b", name, dz32, dz); end
    op32 = 5'd15; #1;
    total++; if (res32 !== hi) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, res32, hi); end
    op32 = 5'd16; #1;
    total++; if (res32 !== lo) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, res32, lo); end
  endtask

  task automatic test_mult;
    int nb, idx;
    launch32(5'd19, 32'hFFFFFFFD, 32'd7);
    wait32(nb, idx);
    check_md("mult", nb, idx, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
  endtask

  task automatic test_stall_back_to_back;
    int nb, idx;
    launch32(5'd20, 32'd3, 32'd5);
    @(negedge clk); #1;
    op32 = 5'd16; #1;
    total++; if (stall32 !== 1'b1 || res32 !== 32'hFFFFFFEB) begin
      bad++; $display("FAIL stall_mflo stall=%b lo=%h want 1/ffffffeb", stall32, res32);
    end
    op32 = 5'd18; a32 = 32'h12345678; #1;
    total++; if (stall32 !== 1'b1) begin bad++; $display("FAIL stall_mtlo got=%b want=1", stall32); end
    op32 = 5'd19; st32 = 1'b1; #1;
    total++; if (stall32 !== 1'b1) begin bad++; $display("FAIL stall_start got=%b want=1", stall32); end
    st32 = 1'b0; op32 = 5'd2; #1;
    total++; if (stall32 !== 1'b0) begin bad++; $display("FAIL stall_add got=%b want=0", stall32); end
    wait32(nb, idx);
    total++; if (idx == 0) begin bad++; $display("FAIL stall_done got=none want=done"); end
    op32 = 5'd16; #1;
    total++; if (res32 !== 32'd15) begin bad++; $display("FAIL multu_lo got=%h want=f", res32); end
    // Start in the DONE cycle goes straight back to RUN.
    op32 = 5'd20; a32 = 32'd6; b32 = 32'd7; st32 = 1'b1;
    @(posedge clk);
    #1 st32 = 1'b0;
    wait32(nb, idx);
    check_md("b2b", nb, idx, 32'h0, 32'd42, 1'b0);
  endtask

  task automatic test_div;
    int nb, idx;
    launch32(5'd21, 32'hFFFFFFF9, 32'd2);
    wait32(nb, idx);
    check_md("div", nb, idx, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    launch32(5'd22, 32'd7, 32'd0);
    wait32(nb, idx);
    check_md("divu0", nb, idx, 32'd7, 32'hFFFFFFFF, 1'b1);
    op32 = 5'd17; a32 = 32'hCAFE0000;
    @(posedge clk);
    #1 op32 = 5'd15; #1;
    total++; if (res32 !== 32'hCAFE0000) begin bad++; $display("FAIL mthi_done got=%h want=cafe0000", res32); end
    launch32(5'd21, 32'h80000000, 32'hFFFFFFFF);
    wait32(nb, idx);
    check_md("divovf", nb, idx, 32'h0, 32'h80000000, 1'b0);
    launch32(5'd22, 32'd100, 32'd7);
    wait32(nb, idx);
    check_md("divu", nb, idx, 32'd2, 32'd14, 1'b0);
    launch32(5'd21, 32'd7, 32'hFFFFFFFE);
    wait32(nb, idx);
    check_md("divneg", nb, idx, 32'd1, 32'hFFFFFFFD, 1'b0);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk); op32 = 5'd17; a32 = 32'h55;
    launch32(5'd19, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags busy=%b done=%b want 0/0", busy32, done32);
    end
    op32 = 5'd15; #1;
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h want=0", res32); end
    op32 = 5'd16; #1;
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h want=0", res32); end
    seen = 0;
    repeat (40) begin @(negedge clk); #1; if (done32) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_nodone got=%0d want=0", seen); end
  endtask

  task automatic test_w16;
    int nb, idx;
    nb = 0; idx = 0;
    @(negedge clk);
    op16 = 5'd20; a16 = 16'hFFFF; b16 = 16'hFFFF; st16 = 1'b1;
    @(posedge clk);
    #1 st16 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk); #1;
      if (done16) begin idx = i; break; end
      if (busy16) nb++;
    end
    total++; if (nb != 16 || idx != 17) begin
      bad++; $display("FAIL w16_latency busy=%0d done_at=%0d want busy=16 done_at=17", nb, idx);
    end
    op16 = 5'd15; #1;
    total++; if (res16 !== 16'hFFFE) begin bad++; $display("FAIL w16_hi got=%h want=fffe", res16); end
    op16 = 5'd16; #1;
    total++; if (res16 !== 16'h0001) begin bad++; $display("FAIL w16_lo got=%h want=0001", res16); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mt();
    test_mult();
    test_stall_back_to_back();
    test_div();
    test_reset_mid();
    test_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64, even.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHAMT_W = log2(WIDTH).
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Ainput  input  WIDTH  operand A (rs).
REQ-006 Binput  input  WIDTH  operand B (rt or extended immediate, selected upstream).
REQ-007 Shamt  input  SHAMT_W  constant shift amount.
REQ-008 Op  input  5  operation select, encoded per REQ-014.
REQ-009 Start  input  1  request to launch the MD op held on Op; effective only when Op is MULT/MULTU/DIV/DIVU.
REQ-010 ALU_Result  output  WIDTH  combinational result of the current Op.
REQ-011 Zero  output  1  high when ALU_Result == 0.
REQ-012 Busy  output  1  high while an MD op iterates; Done  output  1  one-cycle completion pulse; Div_zero  output  1  qualified by Done.
REQ-013 Stall  output  1  high when Busy and Op is MFHI/MFLO/MTHI/MTLO or a Start request.

Function
REQ-014 Op encoding: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 SLLV, 12 SRLV, 13 SRAV, 14 LUI, 15 MFHI, 16 MFLO, 17 MTHI, 18 MTLO, 19 MULT, 20 MULTU, 21 DIV, 22 DIVU; 23..31 give ALU_Result = 0.
REQ-015 ADD/SUB are modulo 2^WIDTH; no overflow output.
REQ-016 SLT signed, SLTU unsigned compare; result is 1 or 0, zero-extended.
REQ-017 SLL/SRL/SRA shift Binput by Shamt; variable shifts use Ainput[SHAMT_W-1:0]; SRA/SRAV sign-fill from Binput[WIDTH-1] over the full width.
REQ-018 LUI gives {Binput[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-019 MFHI/MFLO drive HI/LO register value; MTHI/MTLO drive ALU_Result = Ainput and write HI/LO at the clock edge when Stall is low.
REQ-020 HI, LO are WIDTH-bit registers; they change only on MTHI/MTLO writes and on MD completion.
REQ-021 FSM states IDLE, RUN, DONE; IDLE -> RUN on Start with MD Op; RUN holds exactly WIDTH cycles (iteration counter 0..WIDTH-1) -> DONE; DONE -> RUN on new Start with MD Op, else -> IDLE.
REQ-022 Operands and Op class are latched at the accepting edge; later input changes do not affect the running op.
REQ-023 Busy = (state == RUN); Done = (state == DONE); Start while RUN is ignored and raises Stall.
REQ-024 Latency: Start accepted at edge k -> Done high in the cycle after edge k+WIDTH+1... precisely, Done asserted in cycle k+WIDTH+1 with HI/LO already updated.
REQ-025 MULT/MULTU: shift-add, one partial product per cycle; {HI,LO} = full 2*WIDTH product, signed for MULT (magnitudes then negate if signs differ).
REQ-026 DIV/DIVU: restoring, one quotient bit per cycle; LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-027 Divisor zero: LO = all ones, HI = dividend, Div_zero = 1 with Done; iteration still runs WIDTH cycles.
REQ-028 Signed DIV of most-negative by -1: LO = most-negative, HI = 0, Div_zero = 0.
REQ-029 Start and MTHI/MTLO cannot coincide (single Op); MTHI/MTLO in DONE cycle take effect after the MD result write.

Reset
REQ-030 reset high at an edge: state IDLE, HI = 0, LO = 0, counter = 0, Busy = Done = Div_zero = Stall = 0; an in-flight MD op is discarded.
REQ-031 reset has priority over Start and MTHI/MTLO in the same cycle.

Verification
REQ-032 WIDTH=32, Op=ADD, A=0xFFFFFFFF, B=1 -> ALU_Result=0, Zero=1; Op=SLT, A=0xFFFFFFFF, B=1 -> 1; SLTU -> 0.
REQ-033 Op=SRA, B=0x80000000, Shamt=4 -> 0xF8000000; Op=LUI, B=0x00001234 -> 0x12340000.
REQ-034 MULT A=-3, B=7, Start at edge k -> Busy cycles k+1..k+32, Done at k+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7, Div_zero=1.
REQ-036 MFLO issued during RUN -> Stall=1, LO unchanged; reset asserted mid-RUN -> next cycle Busy=0, HI=LO=0, no Done.
REQ-037 WIDTH=16 build: MULTU 0xFFFF*0xFFFF -> HI=0xFFFE, LO=0x0001, Done 17 cycles after accepting edge.
